// File: rtl/railway_pkg.sv
// Shared definitions for the level-crossing slice: detector state encodings,
// crossing light codes and gate codes.
package railway_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OCCUPIED = 2'd1,
        CLEARING = 2'd2,
        FAULT    = 2'd3
    } det_state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [1:0] OPEN   = 2'd0;
    localparam logic [1:0] CLOSED = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Conditions one raw axle sensor: two-flop synchronizer, debounce filter and a
// registered one-cycle pulse on each filtered 0->1 transition.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [1:0]    fill;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;
    logic          armed;

    // A wheel already on the sensor at reset release must not count: pulses are
    // only emitted once the synchronized sensor has been seen low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            fill    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
            // giving two real flop stages instead of one collapsed wire.
            sync_q1 <= sensor;
            sync_q2 <= sync_q1;
            fill    <= {fill[0], 1'b1};
            if (fill[1] && !sync_q2)
                armed <= 1'b1;

            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            level_d <= level;
            rise    <= armed && level && !level_d;
        end
    end

endmodule

// File: rtl/railway_track_detector.sv
// Axle-counting occupancy detector: counts axles between entry and exit sensors
// and drives the crossing controller's rail_detect level with a fail-safe fault.
module railway_track_detector
    import railway_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int HOLD_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    output logic             rail_detect,
    output logic             occupied,
    output logic [CNT_W-1:0] axle_count,
    output logic             fault,
    output det_state_t       state
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          entry_ev;
    logic          exit_ev;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry (
        .clk    (clk),
        .reset  (reset),
        .sensor (entry_sensor),
        .rise   (entry_ev)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk    (clk),
        .reset  (reset),
        .sensor (exit_sensor),
        .rise   (exit_ev)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            axle_count  <= '0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            rail_detect <= 1'b0;
            occupied    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exit_ev) begin
                        state       <= FAULT;
                        rail_detect <= 1'b1;
                        fault       <= 1'b1;
                    end else if (entry_ev) begin
                        state       <= OCCUPIED;
                        axle_count  <= CNT_W'(1);
                        tmo_cnt     <= '0;
                        rail_detect <= 1'b1;
                        occupied    <= 1'b1;
                    end
                end

                OCCUPIED: begin
                    if (entry_ev && !exit_ev) begin
                        axle_count <= axle_count + 1'b1;
                        tmo_cnt    <= '0;
                        // Reaching the all-ones count means the counter can no longer be trusted.
                        if (axle_count == CNT_MAX - 1'b1) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else if (exit_ev && !entry_ev) begin
                        axle_count <= axle_count - 1'b1;
                        tmo_cnt    <= '0;
                        if (axle_count == CNT_W'(1)) begin
                            state    <= CLEARING;
                            hold_cnt <= HW'(HOLD_CYCLES);
                            occupied <= 1'b0;
                        end
                    end else if (entry_ev) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                CLEARING: begin
                    if (exit_ev) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (entry_ev) begin
                        state      <= OCCUPIED;
                        axle_count <= CNT_W'(1);
                        occupied   <= 1'b1;
                        hold_cnt   <= '0;
                        tmo_cnt    <= '0;
                    end else if (hold_cnt <= HW'(1)) begin
                        state       <= IDLE;
                        hold_cnt    <= '0;
                        rail_detect <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                FAULT: begin
                end
            endcase
        end
    end

endmodule
